// File: rtl/instr_fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
// Optional build macro used by the top: IFETCH_BYPASS_EN.
package instr_fetch_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 16;

  // One buffered instruction together with the PC it was fetched from
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DROP
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle for the fetch stage: instruction-memory request/response
// channel plus the valid/ready channel towards decode.
// master = fetch stage side, slave = memory/decode side.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries. Head is read
// combinationally so a pushed entry is visible to decode the next cycle.
// clear empties the FIFO and wins over push/pop.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               clear,
  output fetch_entry_t       head,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CNT_W'(DEPTH));
  assign count  = count_reg;
  assign head   = mem[rd_ptr_reg];
  assign pop_ok = pop && !empty;

  // Pointer and occupancy tracking; simultaneous push and pop keep count
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // Entry storage, written at the tail slot
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage. Issues requests
// at the current PC, buffers tagged responses and hands them to decode.
// A branch flushes the buffer and discards any in-flight response.
// Build macro IFETCH_BYPASS_EN: forward a response straight to decode
// when the buffer is empty (zero-cycle delivery).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_i,
  output logic            pc_advance_o,
  instr_fetch_if.master   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state_reg, state_next;
  logic [PC_W-1:0]  req_pc_reg, req_pc_next;
  logic             req_valid;
  logic             rsp_take;
  logic             bypass;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     rsp_entry;

  // State and captured request PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FS_IDLE;
      req_pc_reg <= '0;
    end else begin
      state_reg  <= state_next;
      req_pc_reg <= req_pc_next;
    end
  end

  // Next-state, request issue and response acceptance; branch has priority
  always_comb begin
    state_next  = state_reg;
    req_pc_next = req_pc_reg;
    req_valid   = 1'b0;
    rsp_take    = 1'b0;
    case (state_reg)
      FS_IDLE: begin
        req_valid = (fifo_count < CNT_W'(DEPTH)) && !branch_i && !rst;
        if (req_valid && bus.imem_req_ready) begin
          state_next  = FS_WAIT;
          req_pc_next = pc_i;
        end
      end
      FS_WAIT: begin
        if (branch_i) begin
          state_next = bus.imem_rsp_valid ? FS_IDLE : FS_DROP;
        end else if (bus.imem_rsp_valid) begin
          rsp_take   = 1'b1;
          state_next = FS_IDLE;
        end
      end
      FS_DROP: begin
        // The response of the flushed request closes the drop window even
        // if another branch arrives in the same cycle.
        if (bus.imem_rsp_valid) state_next = FS_IDLE;
      end
      default: state_next = FS_IDLE;
    endcase
  end

`ifdef IFETCH_BYPASS_EN
  assign bypass = rsp_take && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign rsp_entry = '{pc: req_pc_reg, instr: bus.imem_rsp_data};
  assign fifo_push = rsp_take && !(bypass && bus.instr_ready);
  assign fifo_pop  = !fifo_empty && bus.instr_ready && !branch_i;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .clear     (branch_i),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = rst ? '0 : pc_i;
  assign pc_advance_o       = !rst && ((req_valid && bus.imem_req_ready) || branch_i);

  // Decode-side outputs: bypassed response, else buffer head, else zero
  always_comb begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.instr_pc    = '0;
    if (!rst) begin
      if (bypass) begin
        bus.instr_valid = 1'b1;
        bus.instr       = bus.imem_rsp_data;
        bus.instr_pc    = req_pc_reg;
      end else if (!fifo_empty) begin
        bus.instr_valid = 1'b1;
        bus.instr       = fifo_head.instr;
        bus.instr_pc    = fifo_head.pc;
      end
    end
  end

  // A response with nothing outstanding is a memory protocol violation
  a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !(state_reg == FS_IDLE && bus.imem_rsp_valid));

  // Issue gating must keep the buffer from overflowing
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: per-cycle comparison against a queue-based
// behavioural model, directed scenarios with literal expectations, then
// randomized traffic with branches and a mid-run reset.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  typedef struct {
    logic [5:0]  pc;
    logic [15:0] ins;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] pc_i;
  logic       branch_i;
  logic       pc_advance_o;

  instr_fetch_if bus ();

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .branch_i     (branch_i),
    .pc_advance_o (pc_advance_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Environment: program counter and instruction memory
  int         cyc;
  logic [5:0] pc_reg;
  bit         mem_pending;
  int         mem_due;
  logic [5:0] mem_addr;

  // Reference model: buffered instructions and the outstanding request
  ent_t       mq[$];
  int         m_out;      // 0 nothing outstanding, 1 live, 2 to be dropped
  logic [5:0] m_req_pc;

  // Observation logs for directed scenarios
  logic [5:0] req_addrs[$];
  int         req_cycles[$];
  logic [5:0] del_pcs[$];
  int         del_cycles[$];

  function automatic logic [15:0] word(input logic [5:0] a);
    return {a, 10'h000} ^ 16'h5A3C ^ {10'h000, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic reset_env();
    mq.delete();
    m_out = 0;
    m_req_pc = '0;
    pc_reg = '0;
    mem_pending = 0;
    cyc = 0;
    req_addrs.delete();
    req_cycles.delete();
    del_pcs.delete();
    del_cycles.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      pc_i = 6'h2A;
      branch_i = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = 16'hFFFF;
      #1;
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_req_addr", 32'(bus.imem_req_addr), 32'd0);
      chk("rst_pc_advance", 32'(pc_advance_o), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'd0);
      chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    branch_i = 1'b0;
    reset_env();
  endtask

  // One clock cycle: drive, compare against the model, then advance both
  task automatic step(input bit mem_rdy, input bit dec_rdy, input bit br,
                      input logic [5:0] tgt, input int lat);
    bit          rsp, e_req, e_fire, e_adv, e_val, byp, dut_fire;
    logic [15:0] rsp_word, e_ins;
    logic [5:0]  e_pc;
    @(negedge clk);
    rsp      = mem_pending && (cyc == mem_due);
    rsp_word = rsp ? word(mem_addr) : 16'($urandom);
    pc_i               = pc_reg;
    branch_i           = br;
    bus.imem_req_ready = mem_rdy;
    bus.instr_ready    = dec_rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp_word;
    #1;
    e_req  = (m_out == 0) && (mq.size() < DEPTH) && !br;
    e_fire = e_req && mem_rdy;
    e_adv  = e_fire || br;
    byp    = 1'b0;
`ifdef IFETCH_BYPASS_EN
    byp    = (mq.size() == 0) && (m_out == 1) && rsp && !br;
`endif
    e_val  = (mq.size() > 0) || byp;
    e_ins  = byp ? rsp_word : ((mq.size() > 0) ? mq[0].ins : 16'h0);
    e_pc   = byp ? m_req_pc : ((mq.size() > 0) ? mq[0].pc : 6'h0);

    chk("req_valid", 32'(bus.imem_req_valid), 32'(e_req));
    chk("pc_advance", 32'(pc_advance_o), 32'(e_adv));
    chk("instr_valid", 32'(bus.instr_valid), 32'(e_val));
    if (e_req) chk("req_addr", 32'(bus.imem_req_addr), 32'(pc_reg));
    if (e_val) begin
      chk("instr", 32'(bus.instr), 32'(e_ins));
      chk("instr_pc", 32'(bus.instr_pc), 32'(e_pc));
    end

    dut_fire = bus.imem_req_valid && mem_rdy;
    if (dut_fire) begin
      req_addrs.push_back(bus.imem_req_addr);
      req_cycles.push_back(cyc);
    end
    if (bus.instr_valid && dec_rdy && !br) begin
      del_pcs.push_back(bus.instr_pc);
      del_cycles.push_back(cyc);
    end

    @(posedge clk);
    if (rsp) mem_pending = 0;
    if (dut_fire) begin
      mem_pending = 1;
      mem_due     = cyc + lat;
      mem_addr    = bus.imem_req_addr;
    end

    if (br) begin
      mq.delete();
      if (m_out == 1)               m_out = rsp ? 0 : 2;
      else if (m_out == 2 && rsp)   m_out = 0;
    end else begin
      if (mq.size() > 0 && dec_rdy) void'(mq.pop_front());
      if (rsp && m_out == 1) begin
        if (!(byp && dec_rdy)) mq.push_back('{pc: m_req_pc, ins: rsp_word});
        m_out = 0;
      end else if (rsp && m_out == 2) begin
        m_out = 0;
      end
      if (e_fire) begin
        m_out    = 1;
        m_req_pc = pc_reg;
      end
    end
    pc_reg = br ? tgt : (e_fire ? pc_reg + 6'd1 : pc_reg);
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    pc_i = '0;
    branch_i = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.instr_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    reset_env();

    // Streaming: latency 2, everything ready -> one request every 3 cycles
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 6'h0, 2);
    chk("s1_req0_addr", 32'(req_addrs[0]), 32'd0);
    chk("s1_req1_addr", 32'(req_addrs[1]), 32'd1);
    chk("s1_req2_addr", 32'(req_addrs[2]), 32'd2);
    chk("s1_req1_cyc", 32'(req_cycles[1]), 32'd3);
    chk("s1_req2_cyc", 32'(req_cycles[2]), 32'd6);
    chk("s1_del0_pc", 32'(del_pcs[0]), 32'd0);
    chk("s1_del2_pc", 32'(del_pcs[2]), 32'd2);
    chk("s1_del0_cyc", 32'(del_cycles[0]), 32'd3);
    chk("s1_del2_cyc", 32'(del_cycles[2]), 32'd9);

    // Decode stalled: buffer fills after two requests, issue stops
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 0, 0, 6'h0, 2);
    chk("s2_req_count", 32'(req_addrs.size()), 32'd2);
    chk("s2_req1_addr", 32'(req_addrs[1]), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 6'h0, 2);
    chk("s2_req2_addr", 32'(req_addrs[2]), 32'd2);
    chk("s2_req2_cyc", 32'(req_cycles[2]), 32'd13);
    chk("s2_del0_pc", 32'(del_pcs[0]), 32'd0);

    // Branch while a request is pending: its late response is discarded
    do_reset();
    step(1, 1, 0, 6'h0, 3);
    step(0, 1, 1, 6'h20, 3);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 6'h0, 3);
    chk("s4_req1_addr", 32'(req_addrs[1]), 32'h20);
    chk("s4_req1_cyc", 32'(req_cycles[1]), 32'd4);
    chk("s4_del0_pc", 32'(del_pcs[0]), 32'h20);
    chk("s4_del_count", 32'(del_pcs.size()), 32'd1);

    // Randomized traffic, reset once mid-run with nothing in flight
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        for (int j = 0; j < 10 && mem_pending; j++) step(0, 1, 0, 6'h0, 1);
        chk("drain_before_reset", 32'(mem_pending), 32'd0);
        do_reset();
      end
      step(bit'($urandom_range(99, 0) < 70),
           bit'($urandom_range(99, 0) < 60),
           bit'($urandom_range(99, 0) < 4),
           6'($urandom),
           int'($urandom_range(3, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
